bf_sweep_ctrl: RTL
==================

# bf_sweep_ctrl

Sequencer that exhaustively exercises the 3-input boolean-function unit (inputs A, B, C; outputs D, E; both outputs implement NOR(A·B, C)). It drives all eight input vectors in order, holds each for a programmable settle time, and samples D and E. It checks both outputs against the golden function and reports pass/fail, the failing-vector count and the first failing vector. It sits between a start/abort source (switch/button logic) and the combinational BF unit, owning that unit's inputs for the duration of a sweep.

## Interface

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling (legal range 0–255)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  sweep request, sampled each cycle
- abort  in  1  cancel the sweep and clear results
- bf_a  out  1  drive to BF unit input A (registered)
- bf_b  out  1  drive to BF unit input B (registered)
- bf_c  out  1  drive to BF unit input C (registered)
- bf_d  in  1  BF unit output D
- bf_e  in  1  BF unit output E
- busy  out  1  sweep in progress
- done  out  1  sweep complete; results valid (level)
- pass  out  1  done with zero failures
- err_cnt  out  4  number of failing vectors, 0–8
- first_fail_vec  out  3  index of the lowest failing vector
- first_fail_valid  out  1  at least one vector failed

## Operation

- Vector index v is 3 bits. Output mapping: bf_a=v[2], bf_b=v[1], bf_c=v[0].
- Golden value: exp(v) = ~((v[2]&v[1]) | v[0]). This gives exp=1 for v=0,2,4 and exp=0 for all other v.
- Vector v fails if bf_d≠exp(v) or bf_e≠exp(v). A vector counts at most once, even if both outputs are wrong.
- FSM states:
  - IDLE: after reset or abort.
  - RUN: vector drive and settle.
  - DONE: results held.
- IDLE/DONE → RUN when start=1 and abort=0. On entry to RUN: v=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0, done=0, pass=0.
- RUN: a settle counter counts 0..SETTLE_CYCLES.
  - On the edge where counter==SETTLE_CYCLES, sample bf_d/bf_e and update err_cnt and first_fail (first_fail is captured only while first_fail_valid=0).
  - On that same edge, if v=7, go to DONE. Otherwise v increments and the counter resets to 0.
- DONE: done=1; pass=(err_cnt==0); results held. bf_a/b/c hold 1,1,1 (the last vector).
- start while busy is ignored.
- abort in any state → IDLE on the next edge. All outputs return to their reset values. Abort wins over a simultaneous start.
- Settle-counter width is max(1, clog2(SETTLE_CYCLES+1)). err_cnt saturates naturally at 8, so no overflow is possible.

## Timing

- Reset values (all asserted immediately on rst, without waiting for clk): bf_a/b/c=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, FSM=IDLE.
- All outputs are registered. No combinational path runs from bf_d/bf_e to any output.
- Start accepted at edge t0: busy=1 and v=0 are visible after t0.
- Each vector occupies SETTLE_CYCLES+1 cycles, so the sweep takes 8·(SETTLE_CYCLES+1) cycles. For the default, busy is high for 24 cycles.
- On the final sample edge, busy falls and done, pass and err_cnt become valid together.
- bf_d/bf_e must be settled in the cycle before the sample edge. With SETTLE_CYCLES=0 there is exactly one cycle of combinational settle.
- Reset mid-sweep: results are lost, and the next start begins from v=0.

## Test plan

- Connect the correct BF model, default parameter, 1-cycle start pulse → vectors 0..7 in order, 3 cycles each; busy high 24 cycles; then done=1, pass=1, err_cnt=0, first_fail_valid=0.
- Force bf_d stuck-at-0, bf_e correct → err_cnt=3, first_fail_vec=0, first_fail_valid=1, pass=0.
- Invert bf_e only when v=7, and also invert both outputs at v=5 → err_cnt=2, first_fail_vec=5.
- Pulse start at cycle 10 of a sweep → ignored, sweep ends at cycle 24. Assert abort during v=3 → next cycle busy=0, bf_*=0, results 0. Assert start+abort together in IDLE → remains IDLE.
- Assert rst asynchronously mid-sweep (between edges) → all outputs zero before the next clk edge. Then a new start completes a full sweep normally.
- SETTLE_CYCLES=0 → sweep 8 cycles, one vector per cycle, correct results. From DONE, start again → results clear on accept and the sweep repeats identically.

Source files
------------

// File: rtl/bf_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// bf_sweep_ctrl
//
// Purpose:
//   Exhaustive sweep sequencer for the 3-input boolean-function (BF) unit
//   whose outputs D and E should both equal NOR(A&B, C). On a start request
//   it walks the input vector v = 0..7 onto the unit (A=v[2], B=v[1],
//   C=v[0]), holds each vector for SETTLE_CYCLES extra cycles, samples D and
//   E on the last cycle of the hold, and accumulates the failure count and
//   the lowest failing vector. Results are held until the next start, an
//   abort or a reset.
//
// Parameters:
//   SETTLE_CYCLES    extra hold cycles per vector before sampling (0..255)
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            sweep request (ignored while busy)
//   abort            cancel sweep, clear results (beats start)
//   bf_a/bf_b/bf_c   registered drive to BF unit inputs A/B/C
//   bf_d/bf_e        BF unit outputs D/E
//   busy             sweep in progress
//   done             sweep finished, results valid (level)
//   pass             done with no failing vectors
//   err_cnt          number of failing vectors, 0..8
//   first_fail_vec   lowest failing vector index
//   first_fail_valid at least one vector failed
// ---------------------------------------------------------------------------
module bf_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       bf_a,
    output logic       bf_b,
    output logic       bf_c,
    input  logic       bf_d,
    input  logic       bf_e,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    // A zero settle time still needs a one-bit counter so the compare below
    // stays well formed; with SETTLE_CYCLES=0 it simply never advances.
    localparam int unsigned CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       vec;
    logic [2:0]       vec_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_next;
    logic             done_next;
    logic             pass_next;
    logic [3:0]       err_cnt_next;
    logic [2:0]       first_fail_vec_next;
    logic             first_fail_valid_next;

    logic             golden;
    logic             vec_fail;
    logic             sample;
    logic [3:0]       err_sum;

    // The vector register is the BF drive: it is a flop, so the unit's inputs
    // are registered, and it naturally rests at 3'b111 once the sweep ends.
    assign bf_a = vec[2];
    assign bf_b = vec[1];
    assign bf_c = vec[0];

    // State register for the FSM and every datapath/result flop. All of them
    // drop to zero immediately on reset, independent of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= 3'd0;
            cnt              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_next;
            vec              <= vec_next;
            cnt              <= cnt_next;
            busy             <= busy_next;
            done             <= done_next;
            pass             <= pass_next;
            err_cnt          <= err_cnt_next;
            first_fail_vec   <= first_fail_vec_next;
            first_fail_valid <= first_fail_valid_next;
        end
    end

    // Next-state and next-result logic. Everything holds by default; the
    // sample edge is the last cycle of a vector's hold window. A vector counts
    // once even if both D and E are wrong. Abort is applied last so it
    // overrides any start or sample decision made in the same cycle.
    always_comb begin
        state_next            = state;
        vec_next              = vec;
        cnt_next              = cnt;
        busy_next             = busy;
        done_next             = done;
        pass_next             = pass;
        err_cnt_next          = err_cnt;
        first_fail_vec_next   = first_fail_vec;
        first_fail_valid_next = first_fail_valid;

        golden   = ~((vec[2] & vec[1]) | vec[0]);
        vec_fail = (bf_d != golden) || (bf_e != golden);
        sample   = (cnt == CNT_LAST);
        err_sum  = err_cnt + {3'd0, vec_fail};

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next            = RUN;
                    vec_next              = 3'd0;
                    cnt_next              = '0;
                    busy_next             = 1'b1;
                    done_next             = 1'b0;
                    pass_next             = 1'b0;
                    err_cnt_next          = 4'd0;
                    first_fail_vec_next   = 3'd0;
                    first_fail_valid_next = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    err_cnt_next = err_sum;
                    if (vec_fail && !first_fail_valid) begin
                        first_fail_vec_next   = vec;
                        first_fail_valid_next = 1'b1;
                    end
                    if (vec == 3'd7) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        pass_next  = (err_sum == 4'd0);
                    end else begin
                        vec_next = vec + 3'd1;
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next            = IDLE;
            vec_next              = 3'd0;
            cnt_next              = '0;
            busy_next             = 1'b0;
            done_next             = 1'b0;
            pass_next             = 1'b0;
            err_cnt_next          = 4'd0;
            first_fail_vec_next   = 3'd0;
            first_fail_valid_next = 1'b0;
        end
    end

endmodule
